// File: rtl/atahost_pkg.sv
// Shared definitions for the ATA host PIO arbiter: bus widths and FSM encoding.
package atahost_pkg;

    localparam int ATA_AW = 4;   // PIO address width, bit 3 selects CS1
    localparam int ATA_DW = 16;  // PIO data width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // sample requests, pick a winner
        ST_XFER = 2'd1,  // PIOreq held, waiting for PIOack
        ST_GAP  = 2'd2   // one cycle of PIOreq low so the request edge re-arms
    } ata_state_e;

endpackage

// File: rtl/atahost_rr_arb2.sv
// Two-way round-robin arbiter with lock override; purely combinational.
module atahost_rr_arb2 (
    input  logic [1:0] req,       // {r1_req, r0_req}
    input  logic       last,      // index of the requester served last
    input  logic       lock_own,  // index of the lock holder
    input  logic       lock_vld,  // lock currently in force
    output logic [1:0] win        // one-hot winner, 00 if nobody eligible
);

    // Lock holder is the only candidate; otherwise ties go to the one not served last.
    always_comb begin
        // NOTE: default first so every path assigns win and no latch is inferred.
        win = 2'b00;
        if (lock_vld) begin
            if (req[lock_own]) begin
                win[lock_own] = 1'b1;
            end
        end else if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/atahost_pio_arbiter.sv
// Shares the OCIDEC-1 PIO port between the register slave (r0) and the
// command sequencer (r1). Registers the winner onto the port, waits for
// PIOack, and returns ack/read data to the owner only.
module atahost_pio_arbiter
    import atahost_pkg::*;
(
    input  logic              clk,
    input  logic              nReset,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_lock,
    input  logic              r1_lock,
    input  logic [ATA_AW-1:0] r0_a,
    input  logic [ATA_AW-1:0] r1_a,
    input  logic [ATA_DW-1:0] r0_d,
    input  logic [ATA_DW-1:0] r1_d,
    input  logic              r0_we,
    input  logic              r1_we,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [ATA_DW-1:0] r0_q,
    output logic [ATA_DW-1:0] r1_q,
    output logic              PIOreq,
    output logic [ATA_AW-1:0] PIOa,
    output logic [ATA_DW-1:0] PIOd,
    output logic              PIOwe,
    input  logic              PIOack,
    input  logic [ATA_DW-1:0] PIOq,
    output logic [1:0]        gnt
);

    ata_state_e        state_q, state_d;
    logic              last_q, last_d;          // requester served last
    logic              lock_vld_q, lock_vld_d;
    logic              lock_own_q, lock_own_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              pio_req_q, pio_req_d;
    logic [ATA_AW-1:0] pio_a_q, pio_a_d;
    logic [ATA_DW-1:0] pio_d_q, pio_d_d;
    logic              pio_we_q, pio_we_d;
    logic [1:0]        ack_q, ack_d;
    logic [ATA_DW-1:0] rd0_q, rd0_d;
    logic [ATA_DW-1:0] rd1_q, rd1_d;

    logic       lock_hold;  // lock input of the current lock holder
    logic       lock_live;  // lock still in force this cycle
    logic       owner;      // index of the requester owning the port
    logic [1:0] win;

    // A lock released while idle stops applying in the same IDLE cycle.
    assign lock_hold = lock_own_q ? r1_lock : r0_lock;
    assign lock_live = lock_vld_q && lock_hold;
    assign owner     = gnt_q[1];

    atahost_rr_arb2 u_arb (
        .req      ({r1_req, r0_req}),
        .last     (last_q),
        .lock_own (lock_own_q),
        .lock_vld (lock_live),
        .win      (win)
    );

    // Next-state and datapath updates for the IDLE/XFER/GAP sequence.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        gnt_d      = gnt_q;
        pio_req_d  = pio_req_q;
        pio_a_d    = pio_a_q;
        pio_d_d    = pio_d_q;
        pio_we_d   = pio_we_q;
        ack_d      = 2'b00;  // acks are single-cycle pulses
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (lock_vld_q && !lock_hold) begin
                    lock_vld_d = 1'b0;
                end
                if (win != 2'b00) begin
                    pio_req_d = 1'b1;
                    gnt_d     = win;
                    pio_a_d   = win[1] ? r1_a  : r0_a;
                    pio_d_d   = win[1] ? r1_d  : r0_d;
                    pio_we_d  = win[1] ? r1_we : r0_we;
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                if (PIOack) begin
                    pio_req_d  = 1'b0;
                    ack_d      = gnt_q;
                    if (!pio_we_q) begin
                        if (owner) rd1_d = PIOq;
                        else       rd0_d = PIOq;
                    end
                    last_d     = owner;
                    lock_own_d = owner;
                    lock_vld_d = owner ? r1_lock : r0_lock;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset drops PIOreq immediately even mid-transfer.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            lock_vld_q <= 1'b0;
            lock_own_q <= 1'b0;
            gnt_q      <= 2'b00;
            pio_req_q  <= 1'b0;
            pio_a_q    <= '0;
            pio_d_q    <= '0;
            pio_we_q   <= 1'b0;
            ack_q      <= 2'b00;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q    <= state_d;
            last_q     <= last_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            gnt_q      <= gnt_d;
            pio_req_q  <= pio_req_d;
            pio_a_q    <= pio_a_d;
            pio_d_q    <= pio_d_d;
            pio_we_q   <= pio_we_d;
            ack_q      <= ack_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    assign PIOreq = pio_req_q;
    assign PIOa   = pio_a_q;
    assign PIOd   = pio_d_q;
    assign PIOwe  = pio_we_q;
    assign gnt    = gnt_q;
    assign r0_ack = ack_q[0];
    assign r1_ack = ack_q[1];
    assign r0_q   = rd0_q;
    assign r1_q   = rd1_q;

endmodule

// File: tb/tb_atahost_pio_arbiter.sv
// Directed bench for atahost_pio_arbiter with a small PIO controller model.
module tb_atahost_pio_arbiter;

    logic        clk;
    logic        nReset;
    logic        r0_req, r1_req, r0_lock, r1_lock;
    logic [3:0]  r0_a, r1_a;
    logic [15:0] r0_d, r1_d;
    logic        r0_we, r1_we;
    logic        r0_ack, r1_ack;
    logic [15:0] r0_q, r1_q;
    logic        PIOreq;
    logic [3:0]  PIOa;
    logic [15:0] PIOd;
    logic        PIOwe;
    logic        PIOack;
    logic [15:0] PIOq;
    logic [1:0]  gnt;

    int n_checks = 0;
    int n_errors = 0;

    // Controller model knobs and monitors
    int          ctl_lat = 3;
    logic [15:0] ctl_q   = 16'h0000;
    int          ctl_cnt = 0;
    int          pio_acks = 0;
    int          r0_acks = 0;
    int          r1_acks = 0;
    int          low_cur = 0;
    int          low_last = 0;

    atahost_pio_arbiter dut (
        .clk     (clk),
        .nReset  (nReset),
        .r0_req  (r0_req),
        .r1_req  (r1_req),
        .r0_lock (r0_lock),
        .r1_lock (r1_lock),
        .r0_a    (r0_a),
        .r1_a    (r1_a),
        .r0_d    (r0_d),
        .r1_d    (r1_d),
        .r0_we   (r0_we),
        .r1_we   (r1_we),
        .r0_ack  (r0_ack),
        .r1_ack  (r1_ack),
        .r0_q    (r0_q),
        .r1_q    (r1_q),
        .PIOreq  (PIOreq),
        .PIOa    (PIOa),
        .PIOd    (PIOd),
        .PIOwe   (PIOwe),
        .PIOack  (PIOack),
        .PIOq    (PIOq),
        .gnt     (gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller model: acks ctl_lat cycles after PIOreq rises, for one cycle.
    initial begin
        PIOack = 1'b0;
        PIOq   = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (PIOreq && !PIOack) begin
                ctl_cnt++;
                if (ctl_cnt >= ctl_lat) begin
                    PIOack = 1'b1;
                    PIOq   = ctl_q;
                    pio_acks++;
                end
            end else begin
                PIOack  = 1'b0;
                ctl_cnt = 0;
            end
        end
    end

    // Monitor: ack pulse counts and length of the last PIOreq-low run.
    initial begin
        forever begin
            @(negedge clk);
            if (!PIOreq) begin
                low_cur++;
            end else begin
                if (low_cur > 0) low_last = low_cur;
                low_cur = 0;
            end
            if (r0_ack) r0_acks++;
            if (r1_ack) r1_acks++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for any requester ack; returns {r1_ack, r0_ack} seen.
    task automatic wait_ack(output logic [1:0] who);
        int n;
        n   = 0;
        who = 2'b00;
        while (n < 60 && who == 2'b00) begin
            @(negedge clk);
            n++;
            who = {r1_ack, r0_ack};
        end
        if (who == 2'b00) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [1:0] who;
        int         a0;
        int         b0;

        nReset  = 1'b0;
        r0_req  = 1'b0; r1_req  = 1'b0;
        r0_lock = 1'b0; r1_lock = 1'b0;
        r0_a    = 4'h0; r1_a    = 4'h0;
        r0_d    = 16'h0; r1_d   = 16'h0;
        r0_we   = 1'b0; r1_we   = 1'b0;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_pioreq", PIOreq, 1'b0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_pioa", PIOa, 4'h0);
        check("rst_piod", PIOd, 16'h0);
        check("rst_piowe", PIOwe, 1'b0);
        check("rst_acks", {r1_ack, r0_ack}, 2'b00);
        check("rst_r0q", r0_q, 16'h0);
        check("rst_r1q", r1_q, 16'h0);

        // Single read by r0
        ctl_lat = 3;
        ctl_q   = 16'h0050;
        r0_a    = 4'h7;
        r0_we   = 1'b0;
        r0_req  = 1'b1;
        @(negedge clk);
        check("rd_pioreq", PIOreq, 1'b1);
        check("rd_pioa", PIOa, 4'h7);
        check("rd_piowe", PIOwe, 1'b0);
        check("rd_gnt", gnt, 2'b01);
        wait_ack(who);
        r0_req = 1'b0;
        check("rd_who", who, 2'b01);
        check("rd_r0q", r0_q, 16'h0050);
        check("rd_r1q", r1_q, 16'h0000);
        repeat (2) @(negedge clk);
        #1;
        check("rd_idle_gnt", gnt, 2'b00);
        check("rd_idle_pioreq", PIOreq, 1'b0);
        check("rd_r1_acks", r1_acks, 0);
        check("rd_r0_acks", r0_acks, 1);

        // Tie after reset: r0 first, then alternation with both held
        @(negedge clk);
        nReset = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        check("tie_rst_r0q", r0_q, 16'h0);
        ctl_lat = 2;
        r0_a = 4'h1; r0_d = 16'h1111; r0_we = 1'b1;
        r1_a = 4'h2; r1_d = 16'h2222; r1_we = 1'b1;
        r0_req = 1'b1;
        r1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ack(who);
            check("tie_who", who, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("tie_pioa", PIOa, (i % 2 == 0) ? 4'h1 : 4'h2);
            check("tie_piod", PIOd, (i % 2 == 0) ? 16'h1111 : 16'h2222);
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        check("tie_r0q_write", r0_q, 16'h0);
        check("tie_r1q_write", r1_q, 16'h0);
        repeat (2) @(negedge clk);

        // Lock: r1 keeps the port for four writes while r0 waits
        ctl_lat = 2;
        r1_a = 4'h2; r1_d = 16'hA5A5; r1_we = 1'b1;
        r1_lock = 1'b1;
        r1_req  = 1'b1;
        @(negedge clk);
        check("lk_first_gnt", gnt, 2'b10);
        r0_a   = 4'h9;
        r0_we  = 1'b0;
        r0_req = 1'b1;
        ctl_q  = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            wait_ack(who);
            check("lk_who", who, 2'b10);
            check("lk_pioa", PIOa, 4'(2 + i));
            check("lk_piod", PIOd, 16'hA5A5 + 16'(i));
            if (i < 3) begin
                r1_a = 4'(3 + i);
                r1_d = 16'hA5A6 + 16'(i);
            end else begin
                r1_req = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lk_stall_gnt", gnt, 2'b00);
        end
        r1_lock = 1'b0;
        @(negedge clk);
        check("lk_release_gnt", gnt, 2'b01);
        wait_ack(who);
        check("lk_r0_who", who, 2'b01);
        check("lk_r0q", r0_q, 16'h1234);
        check("lk_r1q", r1_q, 16'h0);

        // Back-to-back r0 reads: two low cycles between requests, one ack each
        for (int i = 0; i < 2; i++) begin
            r0_a  = 4'(4 + i);
            ctl_q = (i == 0) ? 16'h4444 : 16'h5555;
            a0    = pio_acks;
            wait_ack(who);
            check("b2b_who", who, 2'b01);
            check("b2b_r0q", r0_q, (i == 0) ? 16'h4444 : 16'h5555);
            check("b2b_pioa", PIOa, 4'(4 + i));
            check("b2b_one_ack", pio_acks, a0 + 1);
            check("b2b_low_cycles", low_last, 2);
        end
        r0_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during XFER
        ctl_lat = 6;
        r1_a    = 4'h3;
        r1_we   = 1'b0;
        r1_req  = 1'b1;
        @(negedge clk);
        check("mr_gnt", gnt, 2'b10);
        check("mr_pioreq", PIOreq, 1'b1);
        @(negedge clk);
        nReset = 1'b0;
        r1_req = 1'b0;
        #1;
        check("mr_async_pioreq", PIOreq, 1'b0);
        check("mr_async_gnt", gnt, 2'b00);
        a0 = pio_acks;
        b0 = r0_acks + r1_acks;
        @(negedge clk);
        nReset = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("mr_no_pioack", pio_acks, a0);
        check("mr_no_ack", r0_acks + r1_acks, b0);
        ctl_lat = 2;
        ctl_q   = 16'hBEEF;
        r1_req  = 1'b1;
        wait_ack(who);
        r1_req = 1'b0;
        check("mr_next_who", who, 2'b10);
        check("mr_next_r1q", r1_q, 16'hBEEF);
        repeat (2) @(negedge clk);

        // Discarded request (controller acks the cycle after PIOreq)
        ctl_lat = 1;
        #1;
        b0 = r0_acks;
        r0_a   = 4'h8;
        r0_d   = 16'h0BAD;
        r0_we  = 1'b1;
        r0_req = 1'b1;
        wait_ack(who);
        r0_req = 1'b0;
        check("dis_who", who, 2'b01);
        repeat (4) @(negedge clk);
        #1;
        check("dis_one_ack", r0_acks, b0 + 1);
        check("dis_gnt", gnt, 2'b00);
        check("dis_pioreq", PIOreq, 1'b0);
        check("dis_pioa", PIOa, 4'h8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
